// File: rtl/decode_stage_pkg.sv
// -----------------------------------------------------------------------------
// decode_stage_pkg
// Shared definitions for the RV32 decode stage: ALU op encoding, RV32
// opcode/funct constants, register-index width and the instruction decoder.
// Ports: none (package).
// -----------------------------------------------------------------------------
package decode_stage_pkg;

    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 1 << REG_AW;

    typedef logic [REG_AW-1:0] reg_idx_t;

    typedef enum logic [3:0] {
        OP_SLL  = 4'd0,
        OP_SRL  = 4'd1,
        OP_SRA  = 4'd2,
        OP_ADD  = 4'd3,
        OP_SUB  = 4'd4,
        OP_LUI  = 4'd5,
        OP_SLT  = 4'd6,
        OP_SLTU = 4'd7,
        OP_XOR  = 4'd8,
        OP_OR   = 4'd9,
        OP_AND  = 4'd10,
        OP_MUL  = 4'd11
    } alu_op_e;

    // RV32 major opcodes handled by this stage.
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    // Where the second ALU operand comes from.
    typedef enum logic [1:0] {
        SRC2_REG,
        SRC2_IMM,
        SRC2_SHAMT,
        SRC2_ZERO
    } src2_e;

    typedef struct packed {
        logic    legal;
        alu_op_e op;
        logic    use_rs1;
        logic    use_rs2;
        src2_e   src2;
    } dec_t;

    // funct3 -> op for the funct7=0000000 flavour shared by OP and OP-IMM.
    function automatic alu_op_e base_op(input logic [2:0] f3);
        alu_op_e res;
        res = OP_ADD;
        case (f3)
            F3_ADD_SUB: res = OP_ADD;
            F3_SLL:     res = OP_SLL;
            F3_SLT:     res = OP_SLT;
            F3_SLTU:    res = OP_SLTU;
            F3_XOR:     res = OP_XOR;
            F3_SRL_SRA: res = OP_SRL;
            F3_OR:      res = OP_OR;
            F3_AND:     res = OP_AND;
        endcase
        return res;
    endfunction

    function automatic dec_t decode(input logic [31:0] inst);
        dec_t       d;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = inst[14:12];
        f7 = inst[31:25];
        d  = '{legal: 1'b0, op: OP_ADD, use_rs1: 1'b0, use_rs2: 1'b0, src2: SRC2_ZERO};
        case (inst[6:0])
            OPC_OP: begin
                d.use_rs1 = 1'b1;
                d.use_rs2 = 1'b1;
                d.src2    = SRC2_REG;
                if (f7 == F7_MULDIV) begin
                    d.legal = (f3 == F3_ADD_SUB);
                    d.op    = OP_MUL;
                end else if (f7 == F7_BASE) begin
                    d.legal = 1'b1;
                    d.op    = base_op(f3);
                end else if (f7 == F7_ALT) begin
                    d.legal = (f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA);
                    d.op    = (f3 == F3_ADD_SUB) ? OP_SUB : OP_SRA;
                end
            end
            OPC_OP_IMM: begin
                d.use_rs1 = 1'b1;
                if (f3 == F3_SLL) begin
                    d.legal = (f7 == F7_BASE);
                    d.op    = OP_SLL;
                    d.src2  = SRC2_SHAMT;
                end else if (f3 == F3_SRL_SRA) begin
                    d.legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                    d.op    = (f7 == F7_ALT) ? OP_SRA : OP_SRL;
                    d.src2  = SRC2_SHAMT;
                end else begin
                    d.legal = 1'b1;
                    d.op    = base_op(f3);
                    d.src2  = SRC2_IMM;
                end
            end
            OPC_LUI: begin
                d.legal = 1'b1;
                d.op    = OP_LUI;
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// -----------------------------------------------------------------------------
// decode_stage_if
// Bundles the decode stage's instruction handshake, writeback bus and issue
// outputs. master = upstream/writeback driver side, slave = decode stage.
//   in_valid/in_ready/inst     instruction handshake
//   wb_en/wb_addr/wb_data      register writeback
//   out_valid/op/bitimm/rs1/rs2/rd_addr/illegal  registered issue outputs
// -----------------------------------------------------------------------------
interface decode_stage_if;
    import decode_stage_pkg::*;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] inst;
    logic        wb_en;
    reg_idx_t    wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic [3:0]  op;
    logic [19:0] bitimm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    reg_idx_t    rd_addr;
    logic        illegal;

    modport master (
        output in_valid, inst, wb_en, wb_addr, wb_data,
        input  in_ready, out_valid, op, bitimm, rs1, rs2, rd_addr, illegal
    );

    modport slave (
        input  in_valid, inst, wb_en, wb_addr, wb_data,
        output in_ready, out_valid, op, bitimm, rs1, rs2, rd_addr, illegal
    );

endinterface

// File: rtl/decode_stage_regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
// 32x32 register file with two combinational read ports and one write port,
// plus a one-bit-per-register pending scoreboard.
//   clk, rst          clock, async active-high reset
//   ra1/ra2 -> rd1/rd2  read ports (x0 reads 0; optional writeback bypass)
//   wb_en/wb_addr/wb_data  write port, also clears the pending bit
//   set_en/set_addr   marks a register pending (issue of a new producer)
//   busy              pending bits as seen by this cycle's hazard check
// -----------------------------------------------------------------------------
module regfile_sb
    import decode_stage_pkg::*;
#(
    parameter bit BYPASS = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  reg_idx_t            ra1,
    input  reg_idx_t            ra2,
    output logic [31:0]         rd1,
    output logic [31:0]         rd2,
    input  logic                wb_en,
    input  reg_idx_t            wb_addr,
    input  logic [31:0]         wb_data,
    input  logic                set_en,
    input  reg_idx_t            set_addr,
    output logic [NUM_REGS-1:0] busy
);

    localparam logic [NUM_REGS-1:0] NOT_X0 = {{(NUM_REGS-1){1'b1}}, 1'b0};

    logic [31:0]         regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] set_mask;

    // NOTE: every variable written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (wb_en)  clr_mask[wb_addr]  = 1'b1;
        if (set_en) set_mask[set_addr] = 1'b1;
    end

    // With bypass, a register written this cycle reads the incoming value.
    assign rd1 = (ra1 == '0) ? '0 :
                 (BYPASS && wb_en && (wb_addr == ra1)) ? wb_data : regs[ra1];
    assign rd2 = (ra2 == '0) ? '0 :
                 (BYPASS && wb_en && (wb_addr == ra2)) ? wb_data : regs[ra2];

    // A pending bit being cleared this cycle no longer blocks when bypassing.
    assign busy = BYPASS ? (pending & ~clr_mask) : pending;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    // NOTE: the register array must come up zeroed, so it is built from
    // resettable flops rather than a RAM macro (which cannot be reset).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            pending <= '0;
        end else begin
            if (wb_en && (wb_addr != '0)) regs[wb_addr] <= wb_data;
            // Set is applied after clear so a same-cycle set/clear stays set.
            pending <= ((pending & ~clr_mask) | set_mask) & NOT_X0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// RV32 decode/issue stage for a subset of OP, OP-IMM and LUI. Reads operands,
// stalls on scoreboard hazards and issues one registered ALU operation per
// accepted legal instruction; unsupported instructions are consumed and
// flagged with a one-cycle illegal pulse.
//   clk, rst   clock, async active-high reset
//   bus        decode_stage_if.slave (handshake, writeback, issue outputs)
// -----------------------------------------------------------------------------
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter bit BYPASS = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave bus
);

    dec_t                dec;
    reg_idx_t            rs1_idx;
    reg_idx_t            rs2_idx;
    reg_idx_t            rd_idx;
    logic [31:0]         rf_rd1;
    logic [31:0]         rf_rd2;
    logic [31:0]         opnd1;
    logic [31:0]         opnd2;
    logic [NUM_REGS-1:0] busy;
    logic                stall;
    logic                accept;
    logic                issue;

    assign dec     = decode(bus.inst);
    assign rs1_idx = bus.inst[19:15];
    assign rs2_idx = bus.inst[24:20];
    assign rd_idx  = bus.inst[11:7];

    regfile_sb #(.BYPASS(BYPASS)) u_regfile_sb (
        .clk      (clk),
        .rst      (rst),
        .ra1      (rs1_idx),
        .ra2      (rs2_idx),
        .rd1      (rf_rd1),
        .rd2      (rf_rd2),
        .wb_en    (bus.wb_en),
        .wb_addr  (bus.wb_addr),
        .wb_data  (bus.wb_data),
        .set_en   (issue),
        .set_addr (rd_idx),
        .busy     (busy)
    );

    // rd is checked too, so a newer producer never overtakes an older one.
    // Illegal instructions are consumed regardless of the scoreboard.
    assign stall = bus.in_valid && dec.legal &&
                   ((dec.use_rs1 && busy[rs1_idx]) ||
                    (dec.use_rs2 && busy[rs2_idx]) ||
                    busy[rd_idx]);

    assign bus.in_ready = !stall;
    assign accept       = bus.in_valid && !stall;
    assign issue        = accept && dec.legal;

    assign opnd1 = dec.use_rs1 ? rf_rd1 : '0;

    always_comb begin
        opnd2 = '0;
        case (dec.src2)
            SRC2_REG:   opnd2 = rf_rd2;
            SRC2_IMM:   opnd2 = {{20{bus.inst[31]}}, bus.inst[31:20]};
            SRC2_SHAMT: opnd2 = {27'b0, bus.inst[24:20]};
            default:    opnd2 = '0;
        endcase
    end

    // Payload registers only load on issue, so they hold between issues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.illegal   <= 1'b0;
            bus.op        <= '0;
            bus.bitimm    <= '0;
            bus.rs1       <= '0;
            bus.rs2       <= '0;
            bus.rd_addr   <= '0;
        end else begin
            bus.out_valid <= issue;
            bus.illegal   <= accept && !dec.legal;
            if (issue) begin
                bus.op      <= dec.op;
                bus.bitimm  <= bus.inst[31:12];
                bus.rs1     <= opnd1;
                bus.rs2     <= opnd2;
                bus.rd_addr <= rd_idx;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
// Self-checking bench for decode_stage: directed scenarios followed by random
// instruction/writeback traffic, compared against an instruction-level model.
// -----------------------------------------------------------------------------
module tb_decode_stage;

    localparam bit BYPASS = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    decode_stage_if bus ();

    decode_stage #(.BYPASS(BYPASS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Architectural model state.
    logic [31:0] m_regs [32];
    bit          m_pend [32];

    // Expected issue outputs.
    logic        e_valid, e_illegal, e_lui;
    logic [3:0]  e_op;
    logic [19:0] e_bitimm;
    logic [31:0] e_rs1, e_rs2;
    logic [4:0]  e_rd;
    logic        obs_ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                          input logic [2:0] f3, input int rd);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input int rs1,
                                          input logic [2:0] f3, input int rd);
        return {imm, 5'(rs1), f3, 5'(rd), 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_lui(input int rd, input logic [19:0] imm);
        return {imm, 5'(rd), 7'b0110111};
    endfunction

    // Mnemonic table: kind 0 = reg/reg, 1 = reg/simm12, 2 = reg/shamt, 3 = upper imm.
    function automatic bit ref_decode(input logic [31:0] w, output int op, output int kind);
        logic [16:0] key;
        bit ok;
        key = {w[6:0], w[14:12], w[31:25]};
        ok = 1'b1; op = 0; kind = 0;
        casez (key)
            17'b0110011_000_0000000: op = 3;
            17'b0110011_001_0000000: op = 0;
            17'b0110011_010_0000000: op = 6;
            17'b0110011_011_0000000: op = 7;
            17'b0110011_100_0000000: op = 8;
            17'b0110011_101_0000000: op = 1;
            17'b0110011_110_0000000: op = 9;
            17'b0110011_111_0000000: op = 10;
            17'b0110011_000_0100000: op = 4;
            17'b0110011_101_0100000: op = 2;
            17'b0110011_000_0000001: op = 11;
            17'b0010011_000_???????: begin op = 3;  kind = 1; end
            17'b0010011_010_???????: begin op = 6;  kind = 1; end
            17'b0010011_011_???????: begin op = 7;  kind = 1; end
            17'b0010011_100_???????: begin op = 8;  kind = 1; end
            17'b0010011_110_???????: begin op = 9;  kind = 1; end
            17'b0010011_111_???????: begin op = 10; kind = 1; end
            17'b0010011_001_0000000: begin op = 0;  kind = 2; end
            17'b0010011_101_0000000: begin op = 1;  kind = 2; end
            17'b0010011_101_0100000: begin op = 2;  kind = 2; end
            17'b0110111_???_???????: begin op = 5;  kind = 3; end
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic bit m_busy(input int i);
        if (i == 0 || !m_pend[i]) return 1'b0;
        return !(BYPASS && bus.wb_en && (int'(bus.wb_addr) == i));
    endfunction

    function automatic logic [31:0] m_read(input int i);
        if (i == 0) return '0;
        if (BYPASS && bus.wb_en && (int'(bus.wb_addr) == i)) return bus.wb_data;
        return m_regs[i];
    endfunction

    task automatic drive(input logic v, input logic [31:0] w, input logic we,
                         input int wa, input logic [31:0] wd);
        bus.in_valid = v;
        bus.inst     = w;
        bus.wb_en    = we;
        bus.wb_addr  = 5'(wa);
        bus.wb_data  = wd;
    endtask

    // One clock: predict, check in_ready, advance, check registered outputs.
    task automatic cycle();
        int op, kind, rs1i, rs2i, rdi;
        bit legal, u1, u2, stall, acc;
        logic [31:0] w;
        #1;
        w     = bus.inst;
        legal = ref_decode(w, op, kind);
        rs1i  = int'(w[19:15]);
        rs2i  = int'(w[24:20]);
        rdi   = int'(w[11:7]);
        u1    = (kind != 3);
        u2    = (kind == 0);
        stall = bus.in_valid && legal &&
                ((u1 && m_busy(rs1i)) || (u2 && m_busy(rs2i)) || m_busy(rdi));
        obs_ready = bus.in_ready;
        check("in_ready", obs_ready, !stall);
        acc       = bus.in_valid && !stall;
        e_valid   = acc && legal;
        e_illegal = acc && !legal;
        if (e_valid) begin
            e_op     = 4'(op);
            e_rd     = 5'(rdi);
            e_lui    = (kind == 3);
            e_bitimm = w[31:12];
            e_rs1    = u1 ? m_read(rs1i) : '0;
            case (kind)
                0:       e_rs2 = m_read(rs2i);
                1:       e_rs2 = {{20{w[31]}}, w[31:20]};
                2:       e_rs2 = 32'(rs2i);
                default: e_rs2 = '0;
            endcase
        end
        if (bus.wb_en) begin
            if (bus.wb_addr != 0) m_regs[bus.wb_addr] = bus.wb_data;
            m_pend[bus.wb_addr] = 1'b0;
        end
        if (e_valid && rdi != 0) m_pend[rdi] = 1'b1;
        @(posedge clk);
        #1;
        check("out_valid", bus.out_valid, e_valid);
        check("illegal",   bus.illegal,   e_illegal);
        check("op",        bus.op,        e_op);
        check("rs1",       bus.rs1,       e_rs1);
        check("rs2",       bus.rs2,       e_rs2);
        check("rd_addr",   bus.rd_addr,   e_rd);
        if (e_lui) check("bitimm", bus.bitimm, e_bitimm);
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        foreach (m_regs[i]) m_regs[i] = '0;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        e_valid = 0; e_illegal = 0; e_lui = 0; e_op = 0;
        e_bitimm = 0; e_rs1 = 0; e_rs2 = 0; e_rd = 0;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_illegal",   bus.illegal,   0);
        check("rst_op",        bus.op,        0);
        check("rst_bitimm",    bus.bitimm,    0);
        check("rst_rs1",       bus.rs1,       0);
        check("rst_rs2",       bus.rs2,       0);
        check("rst_rd_addr",   bus.rd_addr,   0);
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0] f7;
        int sel;
        sel = int'($urandom_range(0, 5));
        case (sel)
            0: begin
                case ($urandom_range(0, 3))
                    0:       f7 = 7'b0000000;
                    1:       f7 = 7'b0100000;
                    2:       f7 = 7'b0000001;
                    default: f7 = 7'($urandom);
                endcase
                return enc_r(f7, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                             3'($urandom), int'($urandom_range(0, 7)));
            end
            1: begin
                case ($urandom_range(0, 2))
                    0:       f7 = 7'b0000000;
                    1:       f7 = 7'b0100000;
                    default: f7 = 7'($urandom);
                endcase
                return enc_i({f7, 5'($urandom)}, int'($urandom_range(0, 7)), 3'($urandom),
                             int'($urandom_range(0, 7)));
            end
            2: return enc_lui(int'($urandom_range(0, 7)), 20'($urandom));
            3: return $urandom;
            4: return enc_i(12'($urandom), int'($urandom_range(0, 7)), 3'b000,
                            int'($urandom_range(0, 7)));
            default: return enc_r(7'b0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                                  3'b000, int'($urandom_range(0, 7)));
        endcase
    endfunction

    initial begin
        drive(0, '0, 0, 0, '0);
        #3;
        do_reset();

        // Idle after reset.
        drive(0, '0, 0, 0, '0);
        cycle();

        // ADDI x1,x0,5
        drive(1, enc_i(12'd5, 0, 3'b000, 1), 0, 0, '0);
        cycle();
        check("addi_valid", bus.out_valid, 1);
        check("addi_op",    bus.op,        3);
        check("addi_rs1",   bus.rs1,       0);
        check("addi_rs2",   bus.rs2,       5);
        check("addi_rd",    bus.rd_addr,   1);

        // ADD x2,x1,x1 waits on x1; writeback arrives three cycles after ADDI.
        drive(1, enc_r(7'b0, 1, 1, 3'b000, 2), 0, 0, '0);
        cycle();
        check("raw_stall1", obs_ready, 0);
        cycle();
        check("raw_stall2", obs_ready, 0);
        check("raw_no_issue", bus.out_valid, 0);
        drive(1, enc_r(7'b0, 1, 1, 3'b000, 2), 1, 1, 32'd5);
        cycle();
        check("raw_ready", obs_ready, 1);
        check("raw_valid", bus.out_valid, 1);
        check("raw_rs1",   bus.rs1, 5);
        check("raw_rs2",   bus.rs2, 5);
        check("raw_rd",    bus.rd_addr, 2);
        drive(0, '0, 1, 2, 32'h11);
        cycle();

        // SRAI x3,x4,31 with x4 = 0x80000000, then a bad-funct7 SRAI.
        drive(0, '0, 1, 4, 32'h8000_0000);
        cycle();
        drive(1, enc_i({7'b0100000, 5'd31}, 4, 3'b101, 3), 0, 0, '0);
        cycle();
        check("srai_op",  bus.op,  2);
        check("srai_rs1", bus.rs1, 32'h8000_0000);
        check("srai_rs2", bus.rs2, 31);
        drive(1, enc_i({7'b0100001, 5'd31}, 4, 3'b101, 3), 0, 0, '0);
        cycle();
        check("bad_srai_ready",   obs_ready, 1);
        check("bad_srai_illegal", bus.illegal, 1);
        check("bad_srai_valid",   bus.out_valid, 0);
        check("bad_srai_hold_op", bus.op, 2);
        drive(0, '0, 1, 3, 32'h33);
        cycle();
        check("illegal_pulse_end", bus.illegal, 0);

        // LUI x5,0xABCDE then MUL x6,x5,x5.
        drive(1, enc_lui(5, 20'hABCDE), 0, 0, '0);
        cycle();
        check("lui_op",     bus.op, 5);
        check("lui_bitimm", bus.bitimm, 20'hABCDE);
        check("lui_rs1",    bus.rs1, 0);
        check("lui_rs2",    bus.rs2, 0);
        drive(0, '0, 1, 5, 32'h1234);
        cycle();
        drive(1, enc_r(7'b0000001, 5, 5, 3'b000, 6), 0, 0, '0);
        cycle();
        check("mul_op",  bus.op, 11);
        check("mul_rs1", bus.rs1, 32'h1234);
        drive(0, '0, 1, 6, 32'h66);
        cycle();

        // Writes to x0 are ignored.
        drive(0, '0, 1, 0, 32'hFFFF_FFFF);
        cycle();
        drive(1, enc_r(7'b0, 0, 0, 3'b000, 7), 0, 0, '0);
        cycle();
        check("x0_ready", obs_ready, 1);
        check("x0_rs1",   bus.rs1, 0);
        check("x0_rs2",   bus.rs2, 0);
        drive(0, '0, 1, 7, 32'h77);
        cycle();

        // Same-cycle issue and writeback of x1: pending must stay set.
        drive(1, enc_i(12'd1, 0, 3'b000, 1), 1, 1, 32'h99);
        cycle();
        drive(1, enc_r(7'b0, 0, 1, 3'b000, 2), 0, 0, '0);
        cycle();
        check("setclr_stall", obs_ready, 0);
        drive(1, enc_r(7'b0, 0, 1, 3'b000, 2), 1, 1, 32'hAA);
        cycle();
        check("setclr_rs1", bus.rs1, 32'hAA);
        drive(0, '0, 1, 2, 32'h22);
        cycle();

        // Reset in the middle of a stall drops the stalled instruction.
        drive(1, enc_i(12'd9, 0, 3'b000, 1), 0, 0, '0);
        cycle();
        drive(1, enc_r(7'b0, 1, 1, 3'b000, 2), 0, 0, '0);
        cycle();
        check("pre_rst_stall", obs_ready, 0);
        do_reset();
        cycle();
        check("post_rst_ready", obs_ready, 1);
        check("post_rst_valid", bus.out_valid, 1);
        check("post_rst_rs1",   bus.rs1, 0);
        drive(0, '0, 1, 2, 32'h5);
        cycle();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 3) != 0, rand_inst(), $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 7)), $urandom);
            cycle();
        end

        drive(0, '0, 0, 0, '0);
        cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter: BYPASS, 1, 1 = wb_data forwarded to same-cycle reads of wb_addr; 0 = read sees old value and the hazard stalls one extra cycle.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  inst holds an instruction.
REQ-005 in_ready  output  1  stage accepts inst this cycle.
REQ-006 inst  input  32  RV32 instruction word.
REQ-007 wb_en  input  1  writeback strobe.
REQ-008 wb_addr  input  5  writeback register index.
REQ-009 wb_data  input  32  writeback value.
REQ-010 out_valid  output  1  outputs hold one issued ALU operation; one-cycle pulse per issue.
REQ-011 op  output  4  ALU opcode, encoding per REQ-015.
REQ-012 bitimm  output  20  inst[31:12], meaningful for LUI only.
REQ-013 rs1 / rs2  output  32 each  ALU operands.
REQ-014 rd_addr  output  5  destination index, returned later on wb_addr.
REQ-040 illegal  output  1  one-cycle pulse when an unsupported instruction is consumed.

Function
REQ-015 op encoding SHALL be SLL=0, SRL=1, SRA=2, ADD=3, SUB=4, LUI=5, SLT=6, SLTU=7, XOR=8, OR=9, AND=10, MUL=11.
REQ-016 OP (0110011) SHALL decode ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND on funct7 0000000/0100000, and MUL on funct7 0000001 with funct3 000.
REQ-017 OP-IMM (0010011) SHALL decode ADDI, SLTI, SLTIU, XORI, ORI, ANDI; rs2 = sign-extended inst[31:20].
REQ-018 SLLI, SRLI, SRAI SHALL require funct7 0000000/0000000/0100000; rs2 = zero-extended shamt inst[24:20].
REQ-019 LUI (0110111) SHALL issue op=5 with bitimm=inst[31:12]; rs1 = rs2 = 0.
REQ-020 Any other opcode/funct combination SHALL be illegal: consumed, illegal=1 next cycle, out_valid=0, no state change.
REQ-021 Register file: 32x32, two combinational reads, one write on wb_en; x0 reads 0 and ignores writes.
REQ-022 Scoreboard: one pending bit per register; set at issue for rd!=0; cleared on wb_en for wb_addr; x0 never pending.
REQ-023 Same-cycle set and clear of the same index SHALL leave the bit set.
REQ-024 Stall SHALL be in_valid and a legal inst whose used rs1, used rs2, or rd is pending; with BYPASS=1 a pending bit cleared by this cycle's wb_en does not stall.
REQ-025 in_ready SHALL be !stall, combinational; illegal instructions never stall.
REQ-026 Accept = in_valid && in_ready; outputs SHALL be registered with one-cycle latency.
REQ-027 When not issuing, op/bitimm/rs1/rs2/rd_addr SHALL hold their last values and out_valid=0.
REQ-028 Downstream has no backpressure; back-to-back independent instructions SHALL issue every cycle.

Reset
REQ-029 Reset SHALL clear the register file, all pending bits, and all outputs to 0 (in_ready follows REQ-025).
REQ-030 Reset mid-stall SHALL drop the stalled instruction; the next in_valid is a fresh accept.

Structure
REQ-031 Shared package SHALL hold the op encoding constants, RV32 opcode/funct3/funct7 constants, and the register-index width.
REQ-032 Decode logic SHALL be a combinational function or block; register file plus scoreboard SHALL be one sub-module, regfile_sb.

Verification
REQ-033 After reset, ADDI x1,x0,5 -> next cycle out_valid=1, op=3, rs1=0, rs2=5, rd_addr=1.
REQ-034 ADDI x1; ADD x2,x1,x1 with wb of x1=5 three cycles later -> in_ready=0 until wb; with BYPASS=1 issue in the wb cycle with rs1=rs2=5.
REQ-035 SRAI x3,x4,31 with x4=0x80000000 -> op=2, rs2=31; SRAI with funct7 0100001 -> illegal pulse, no out_valid.
REQ-036 LUI x5,0xABCDE -> op=5, bitimm=0xABCDE; MUL x6,x5,x5 -> op=11, funct7 0000001 path covered.
REQ-037 wb_en to x0 with 0xFFFFFFFF, then ADD x7,x0,x0 -> rs1=rs2=0, no stall.
REQ-038 rst asserted mid-stall -> out_valid=0 and pending clear on the cycle rst deasserts; next inst issues without stall.
